pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards between ID and EX.
//  - Flushes wrong-path stages on a branch taken in MEM.
//  - Freezes the pipeline while the data memory is not ready.
//  Drives the hold/flush inputs of PC, IFID, IDEX, EXMEM and MEMWB, and keeps
//  saturating performance counters for stall and flush events.
// PARAMETERS
//  REG_NUM_W   5      register-number width (matches RegNumPath)
//  WAIT_LIMIT  255    max consecutive memory-wait cycles before a timeout error
//  CNT_W       16     width of the performance counters
// PORTS
//  clk             in   1      clock; all state updates on the rising edge
//  rst             in   1      asynchronous, active-low reset
//  idRs            in   5      rs field of the instruction in ID
//  idRt            in   5      rt field of the instruction in ID
//  idUsesRt        in   1      ID instruction reads rt (R-type, store, beq)
//  exMemRead       in   1      EX holds a load
//  exWrNum         in   5      destination register of the EX instruction
//  memBranchTaken  in   1      branchToMEM & isEqualToMem
//  memAccess       in   1      MEM holds a valid load or store
//  dmemReady       in   1      data memory completes the access this cycle
//  pcHold          out  1      PC keeps its value
//  ifidHold        out  1      IFID keeps its value
//  ifidFlush       out  1      IFID loads a NOP
//  idexHold        out  1      IDEX keeps its value
//  idexFlush       out  1      IDEX loads a bubble (all control bits 0)
//  exmemHold       out  1      EXMEM keeps its value
//  exmemFlush      out  1      EXMEM loads a bubble
//  memwbBubble     out  1      MEMWB loads a bubble (regWrite = 0)
//  memTimeout      out  1      sticky error flag: wait exceeded WAIT_LIMIT
//  stallCnt        out  CNT_W  saturating count of stalled cycles (load-use + memory)
//  flushCnt        out  CNT_W  saturating count of taken-branch flushes
// BEHAVIOUR
//  Reset (rst = 0, asynchronous)
//   - state = RUN; waitCnt, stallCnt, flushCnt and memTimeout = 0.
//   - All hold/flush/bubble outputs = 0 while rst is low.
//  Control outputs are combinational from state and inputs: zero-latency, they
//  act at the next clock edge.
//  FSM states: RUN, MEM_WAIT.
//   RUN -> MEM_WAIT   when memAccess & !dmemReady
//   MEM_WAIT -> RUN   when dmemReady, or when waitCnt == WAIT_LIMIT
//   On timeout: memTimeout is set (sticky until reset) and the access is forced
//   to complete.
//  Memory freeze (priority 1): (RUN & memAccess & !dmemReady) or (MEM_WAIT & !dmemReady & !timeout)
//   - Asserts pcHold, ifidHold, idexHold, exmemHold and memwbBubble.
//   - All flushes are 0. memBranchTaken is ignored and handled after release.
//  Branch flush (priority 2): memBranchTaken and no freeze
//   - Asserts ifidFlush, idexFlush and exmemFlush; all holds are 0 (PC takes the target).
//   - flushCnt += 1. A load-use hazard in the same cycle is ignored.
//  Load-use stall (priority 3):
//   - Condition: exMemRead & exWrNum != 0 & (exWrNum == idRs | (idUsesRt & exWrNum == idRt))
//   - Asserts pcHold, ifidHold and idexFlush for exactly one cycle (EX then holds a bubble).
//  stallCnt += 1 on every freeze or load-use cycle. Both counters saturate at all-ones.
//  waitCnt: increments in MEM_WAIT; cleared on entering RUN; width = clog2(WAIT_LIMIT + 1).
//  Mid-operation reset: the FSM returns to RUN immediately, and the freeze releases
//  asynchronously.
// STRUCTURE
//  Types.v
//   - Add `CtrlStatePath and constants CTRL_RUN / CTRL_MEM_WAIT.
//   - Reuse `RegNumPath.
//  Sub-module: sat_counter #(CNT_W), instantiated twice (stallCnt, flushCnt).
//   Ports: clk, rst, inc, count.
//  Hazard compare and priority mux live in a single always_comb; the FSM and waitCnt
//  use always_ff.
// TESTING
//  1. lw $2 in EX, add $3,$2,$4 in ID -> one cycle of pcHold = ifidHold = idexFlush = 1;
//     next cycle all 0; stallCnt = 1.
//  2. lw $0 in EX, ID reads $0 -> no stall.
//     Same case with idUsesRt = 0 and a match on rt only -> no stall.
//  3. memBranchTaken = 1 with a load-use hazard in the same cycle -> ifid/idex/exmem flush = 1,
//     pcHold = 0; flushCnt = 1; stallCnt unchanged.
//  4. memAccess = 1, dmemReady low for 3 cycles -> all holds + memwbBubble for 3 cycles,
//     state MEM_WAIT; release on ready; stallCnt = 3.
//  5. dmemReady stuck low with WAIT_LIMIT = 4 -> memTimeout rises after the limit and
//     stays high; FSM returns to RUN.
//  6. rst pulled low during MEM_WAIT -> all outputs 0 asynchronously; counters = 0;
//     RUN after release.
//  Counter saturation: force stallCnt to all-ones, stall again -> stays all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding and control-bundle constants
// for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;
    typedef enum logic {CTRL_RUN, CTRL_MEM_WAIT} ctrl_state_e;
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_hold;
        logic idex_flush;
        logic exmem_hold;
        logic exmem_flush;
        logic memwb_bubble;
    } ctrl_t;
    localparam ctrl_t CTRL_NONE   = 8'b0000_0000;
    localparam ctrl_t CTRL_FREEZE = 8'b1101_0101;
    localparam ctrl_t CTRL_FLUSH  = 8'b0010_1010;
    localparam ctrl_t CTRL_STALL  = 8'b1100_1000;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and the hold/flush,
// status and counter outputs back to it.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_NUM_W = 5,
    parameter int CNT_W     = 16
);
    logic [REG_NUM_W-1:0] id_rs, id_rt, ex_wr_num;
    logic                 id_uses_rt, ex_mem_read, mem_branch_taken, mem_access, dmem_ready;
    logic                 pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
    logic                 exmem_hold, exmem_flush, memwb_bubble, mem_timeout;
    logic [CNT_W-1:0]     stall_cnt, flush_cnt;
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_wr_num, mem_branch_taken, mem_access, dmem_ready,
        input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, exmem_flush,
               memwb_bubble, mem_timeout, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_wr_num, mem_branch_taken, mem_access, dmem_ready,
        output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, exmem_flush,
               memwb_bubble, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = inc && !(&count_q) ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; memory
// freeze beats branch flush beats load-use stall. rst is asynchronous, active-low.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_NUM_W  = 5,
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              timeout, freeze, branch, load_use;
    ctrl_t             ctrl;
    always_comb begin
        timeout       = state_q == CTRL_MEM_WAIT && wait_cnt_q == WAIT_MAX;
        freeze        = !hz.dmem_ready && (state_q == CTRL_RUN ? hz.mem_access : !timeout);
        branch        = hz.mem_branch_taken && !freeze;
        load_use      = hz.ex_mem_read && hz.ex_wr_num != '0 &&
                        (hz.ex_wr_num == hz.id_rs || (hz.id_uses_rt && hz.ex_wr_num == hz.id_rt));
        // outputs are gated by rst so the freeze drops the moment reset asserts
        ctrl          = !rst    ? CTRL_NONE   :
                        freeze  ? CTRL_FREEZE :
                        branch  ? CTRL_FLUSH  :
                        load_use ? CTRL_STALL : CTRL_NONE;
        state_d       = state_q == CTRL_RUN ?
                        (hz.mem_access && !hz.dmem_ready ? CTRL_MEM_WAIT : CTRL_RUN) :
                        (hz.dmem_ready || timeout ? CTRL_RUN : CTRL_MEM_WAIT);
        wait_cnt_d    = state_q == CTRL_MEM_WAIT && state_d == CTRL_MEM_WAIT ? wait_cnt_q + 1'b1 : '0;
        mem_timeout_d = mem_timeout_q || timeout;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q       <= CTRL_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    assign {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_hold, hz.idex_flush,
            hz.exmem_hold, hz.exmem_flush, hz.memwb_bubble} = ctrl;
    assign hz.mem_timeout = mem_timeout_q;
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(ctrl.pc_hold), .count(hz.stall_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(branch && rst), .count(hz.flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for the stall/flush sequencer,
// run with a short wait limit and narrow counters so timeout and saturation are reachable.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;
    localparam int CNT_W = 4;
    localparam int WL    = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] FRZ  = 8'b1101_0101;
    localparam logic [7:0] BR   = 8'b0010_1010;
    localparam logic [7:0] LU   = 8'b1100_1000;
    localparam logic RUN = 1'b0;
    localparam logic WT  = 1'b1;
    typedef struct packed {
        logic [7:0] ctrl;
        logic       st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_NUM_W(5), .CNT_W(CNT_W)) hz ();
    pipeline_hazard_ctrl #(.REG_NUM_W(5), .WAIT_LIMIT(WL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .hz(hz)
    );

    int   checks = 0, errors = 0;
    int   exp_stall = 0, exp_flush = 0;
    logic exp_to = 1'b0;
    exp_t sb[$];
    wire [7:0] obs = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_hold, hz.idex_flush,
                      hz.exmem_hold, hz.exmem_flush, hz.memwb_bubble};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic mr,
                         input logic [4:0] wr, input logic mb, input logic ma, input logic rdy);
        hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = ur; hz.ex_mem_read = mr;
        hz.ex_wr_num = wr; hz.mem_branch_taken = mb; hz.mem_access = ma; hz.dmem_ready = rdy;
    endtask

    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic mr, input logic [4:0] wr, input logic mb, input logic ma,
                        input logic rdy, input logic [7:0] ec, input logic es);
        exp_t e;
        drive(rs, rt, ur, mr, wr, mb, ma, rdy);
        sb.push_back('{ctrl: ec, st: es});
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, "_ctrl"}, 32'(obs), 32'(e.ctrl));
        chk({tag, "_state"}, 32'(dut.state_q), 32'(e.st));
        chk({tag, "_stall"}, 32'(hz.stall_cnt), 32'(exp_stall));
        chk({tag, "_flush"}, 32'(hz.flush_cnt), 32'(exp_flush));
        chk({tag, "_timeout"}, 32'(hz.mem_timeout), 32'(exp_to));
        if (e.ctrl[7] && exp_stall < SAT) exp_stall++;
        if (e.ctrl[5] && exp_flush < SAT) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        #12;
        chk("rst_ctrl", 32'(obs), 32'(NONE));
        chk("rst_state", 32'(dut.state_q), 32'(RUN));
        chk("rst_stall", 32'(hz.stall_cnt), 0);
        chk("rst_flush", 32'(hz.flush_cnt), 0);
        chk("rst_timeout", 32'(hz.mem_timeout), 0);
        @(posedge clk);
        #1;
        drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        // load-use on rs, then clear
        step("lu_rs",     5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, LU,   RUN);
        step("lu_after",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        chk("lu_stall_is_1", 32'(hz.stall_cnt), 1);
        step("lu_r0",     5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        step("lu_rt_nou", 5'd5, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, NONE, RUN);
        step("lu_rt_use", 5'd5, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, LU,   RUN);
        step("lu_noload", 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, NONE, RUN);
        // branch beats load-use
        step("br_lu",     5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, BR,   RUN);
        step("br_after",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        chk("br_flush_is_1", 32'(hz.flush_cnt), 1);
        // three-cycle memory wait, branch deferred until release
        step("mw_0",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  RUN);
        step("mw_1",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  WT);
        step("mw_2_br",   5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, FRZ,  WT);
        step("mw_rel_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, BR,   WT);
        step("mw_done",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        chk("mw_stall_is_5", 32'(hz.stall_cnt), 5);
        // ready stuck low: timeout after WL cycles in MEM_WAIT
        step("to_run",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  RUN);
        for (int i = 0; i < WL; i++)
            step("to_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, WT);
        step("to_hit",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, NONE, WT);
        exp_to = 1'b1;
        step("to_back",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE, RUN);
        step("to_sticky", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        // saturation of the stall counter
        for (int i = 0; i < 7; i++)
            step("sat_lu", 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, LU, RUN);
        step("sat_idle",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        chk("sat_stall_max", 32'(hz.stall_cnt), SAT);
        // asynchronous reset in the middle of a memory wait
        step("ar_run",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  RUN);
        step("ar_wait",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ,  WT);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ctrl", 32'(obs), 32'(NONE));
        chk("ar_state", 32'(dut.state_q), 32'(RUN));
        chk("ar_stall", 32'(hz.stall_cnt), 0);
        chk("ar_flush", 32'(hz.flush_cnt), 0);
        chk("ar_timeout", 32'(hz.mem_timeout), 0);
        exp_stall = 0;
        exp_flush = 0;
        exp_to    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("ar_idle",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        step("ar_lu",     5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, LU,   RUN);
        step("ar_end",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE, RUN);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
